mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised sequential multiply/divide unit for the MIPS datapath.
- Replaces the fixed 32-bit unsigned shift-add multiplier.
- Executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands and delivers a HI/LO result pair.
- The control FSM drives it through a start/busy/done handshake instead of mirroring the control state.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived localparam, not overridable.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- lhs  input  WIDTH  multiplicand / dividend; sampled with start.
- rhs  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high from the accept edge until the edge that raises done.
- done  output  1  single-cycle pulse when hi/lo/div_by_zero are valid.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.
- div_by_zero  output  1  set with done when a DIV/DIVU had rhs=0; cleared on the next accept.

Behaviour:
- Reset (synchronous): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; counter and internal registers cleared.
- Reset mid-operation aborts the operation at that edge. No done pulse is produced.
- States: IDLE, WORK, FIX.
- IDLE, start=1 at edge E0: latch op and the operand magnitudes, with the sign taken only for op[0]=1. Record result signs; counter=0; busy=1; next state WORK.
- IDLE, start=0: hold; hi/lo keep their last result.
- WORK, multiply: one iteration per edge.
  - Iteration: if multiplier LSB=1, accumulator += multiplicand (2*WIDTH bits); then multiplicand <<1, multiplier >>1.
- WORK, divide: restoring division, one bit per edge.
  - Iteration: shift remainder:dividend left 1; if remainder >= divisor, subtract and set the quotient bit.
- WORK counter increments each iteration. After WIDTH iterations (edges E1..E_WIDTH) go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply sign correction (two's-complement negate where needed) and write hi/lo.
  - Pulse done=1 for exactly one cycle; busy=0; next state IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH+1, i.e. WIDTH+2 edges after start is sampled.
- Back-to-back: start may be asserted in the done cycle; it is accepted at that edge.
- start while busy=1 is ignored; latched operands and op are unaffected.
- Signed multiply: the product is negated iff the operand signs differ.
- Signed divide:
  - Quotient truncates toward zero; it is negated iff the signs differ.
  - Remainder takes the sign of the dividend.
- Overflow: DIV of -2^(WIDTH-1) by -1 gives lo=-2^(WIDTH-1) (wraps), hi=0, div_by_zero=0.
- Divide by zero:
  - Same latency as any other operation.
  - Results: lo = all ones, hi = lhs as sampled, div_by_zero=1.
- Multiply never sets div_by_zero.
- hi, lo and div_by_zero are stable between done pulses.
- Inputs are don't-care while busy=1.

Decomposition:
- Package mult_div_pkg holds:
  - op_t enum {OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11};
  - md_state_t enum {MD_IDLE, MD_WORK, MD_FIX};
  - the helper function abs_val(value, is_signed).
- The block is a single module with no sub-module. The multiply and divide datapaths share the 2*WIDTH working register and the counter.

Test Plan (WIDTH=32 unless noted):
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after the start edge; busy high throughout.
- MULT 0xFFFFFFFD (-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1; next MULTU 2*3 -> div_by_zero=0, lo=6, hi=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0; DIVU 7/7 -> lo=1, hi=0.
- Busy and reset handling:
  - Start DIVU 1000/3; pulse start with different operands at iteration 5 -> ignored; result lo=333, hi=1.
  - Start again; assert reset at iteration 10 -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
- WIDTH=8 instance: MULT 0x80 * 0x80 -> hi=0x40, lo=0x00; done 10 edges after start; back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared op/state types and magnitude helper for the multiply/divide unit
package mult_div_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_WORK, MD_FIX} md_state_t;
  function automatic logic [63:0] abs_val(input logic [63:0] value, input logic is_signed);
    return (is_signed && value[63]) ? -value : value;
  endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential shift-add multiply / restoring divide with start/busy/done handshake
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  md_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0] wk, mcand, wk_next, prod;
  logic [WIDTH-1:0] mplier, lhs_mag, rhs_mag, quo, rem;
  logic [WIDTH:0] trial;
  logic is_div, neg_q, neg_r, dbz;
  always_comb begin
    lhs_mag = WIDTH'(abs_val(64'($signed(lhs)), op[0]));
    rhs_mag = WIDTH'(abs_val(64'($signed(rhs)), op[0]));
    // remainder stays below the divisor, so a W+1 bit trial subtract never loses the shifted-out bit
    trial = wk[W2-1:WIDTH-1] - {1'b0, mplier};
    wk_next = is_div ? (trial[WIDTH] ? {wk[W2-2:0], 1'b0} : {trial[WIDTH-1:0], wk[WIDTH-2:0], 1'b1})
                     : (mplier[0] ? wk + mcand : wk);
    quo = wk[WIDTH-1:0];
    rem = wk[W2-1:WIDTH];
    prod = neg_q ? -wk : wk;
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= MD_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      wk <= '0;
      mcand <= '0;
      mplier <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: if (start) begin
          wk <= op[1] ? {{WIDTH{1'b0}}, lhs_mag} : '0;
          mcand <= {{WIDTH{1'b0}}, lhs_mag};
          mplier <= rhs_mag;
          is_div <= op[1];
          neg_q <= op[0] & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
          neg_r <= op[0] & lhs[WIDTH-1];
          dbz <= op[1] & ~|rhs;
          div_by_zero <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          state <= MD_WORK;
        end
        MD_WORK: begin
          wk <= wk_next;
          mcand <= mcand << 1;
          mplier <= is_div ? mplier : mplier >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= MD_FIX;
        end
        MD_FIX: begin
          hi <= is_div ? (neg_r ? -rem : rem) : prod[W2-1:WIDTH];
          lo <= is_div ? (dbz ? {WIDTH{1'b1}} : (neg_q ? -quo : quo)) : prod[WIDTH-1:0];
          div_by_zero <= dbz;
          done <= 1'b1;
          busy <= 1'b0;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for 32-bit and 8-bit multiply/divide instances
module tb_mult_div_unit;
  import mult_div_pkg::*;
  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic dbz;
    string name;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start8 = 1'b0;
  logic [1:0] op = 2'b00, op8 = 2'b00;
  logic [31:0] lhs = '0, rhs = '0, hi, lo;
  logic [7:0] lhs8 = '0, rhs8 = '0, hi8, lo8;
  logic busy, done, dbz, busy8, done8, dbz8;
  int compared = 0, mismatched = 0, edges = 0, dones = 0, dones8 = 0;
  exp_t q32[$], q8[$];
  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(clk), .reset(reset), .start(start), .op(op), .lhs(lhs), .rhs(rhs),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );
  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clk(clk), .reset(reset), .start(start8), .op(op8), .lhs(lhs8), .rhs(rhs8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges++;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon32
    exp_t e;
    if (done === 1'b1) begin
      dones++;
      if (q32.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done32: got done=1 expected no pending result");
      end else begin
        e = q32.pop_front();
        check({e.name, "_hi"}, 64'(hi), e.hi);
        check({e.name, "_lo"}, 64'(lo), e.lo);
        check({e.name, "_dbz"}, 64'(dbz), 64'(e.dbz));
      end
    end
  end
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      dones8++;
      if (q8.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done8: got done=1 expected no pending result");
      end else begin
        e = q8.pop_front();
        check({e.name, "_hi"}, 64'(hi8), e.hi);
        check({e.name, "_lo"}, 64'(lo8), e.lo);
        check({e.name, "_dbz"}, 64'(dbz8), 64'(e.dbz));
      end
    end
  end
  task automatic wait32(input int n0, input string name);
    int low = 0;
    while (done !== 1'b1 && edges - n0 < 80) begin
      if (busy !== 1'b1) low++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(edges - n0 + 1), 64'd34);
    check({name, "_busy_held"}, 64'(low), 64'd0);
    check({name, "_busy_cleared"}, 64'(busy), 64'd0);
  endtask
  task automatic wait8(input int n0, input string name);
    while (done8 !== 1'b1 && edges - n0 < 40) @(negedge clk);
    check({name, "_latency"}, 64'(edges - n0 + 1), 64'd10);
  endtask
  task automatic run32(input op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input string name);
    int n0;
    @(negedge clk);
    op = o;
    lhs = a;
    rhs = b;
    start = 1'b1;
    n0 = edges + 1;
    q32.push_back('{64'(eh), 64'(el), ed, name});
    @(negedge clk);
    start = 1'b0;
    wait32(n0, name);
  endtask
  task automatic issue8(input op_t o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el, input string name, output int n0);
    op8 = o;
    lhs8 = a;
    rhs8 = b;
    start8 = 1'b1;
    n0 = edges + 1;
    q8.push_back('{64'(eh), 64'(el), 1'b0, name});
    @(negedge clk);
    start8 = 1'b0;
  endtask
  initial begin
    int n0;
    int d0;
    repeat (3) @(negedge clk);
    check("reset_flags32", 64'({busy, done, dbz}), 64'd0);
    check("reset_hi32", 64'(hi), 64'd0);
    check("reset_lo32", 64'(lo), 64'd0);
    check("reset_flags8", 64'({busy8, done8, dbz8}), 64'd0);
    reset = 1'b0;
    run32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
    run32(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg3x7");
    run32(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg7by2");
    run32(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, "divu_by0");
    run32(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_2x3");
    run32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, "div_overflow");
    run32(OP_DIVU, 32'd7, 32'd7, 32'd0, 32'd1, 1'b0, "divu_7by7");
    run32(OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_neg_by0");
    run32(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0, 32'd25, 1'b0, "mult_neg5sq");
    run32(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, "divu_big");
    run32(OP_MULT, 32'd0, 32'h80000000, 32'd0, 32'd0, 1'b0, "mult_zero");
    @(negedge clk);
    op = OP_DIVU;
    lhs = 32'd1000;
    rhs = 32'd3;
    start = 1'b1;
    n0 = edges + 1;
    q32.push_back('{64'd1, 64'd333, 1'b0, "divu_ignore"});
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = OP_MULTU;
    lhs = 32'd55;
    rhs = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lhs = 32'd12345;
    wait32(n0, "divu_ignore");
    repeat (3) @(negedge clk);
    check("stable_hi", 64'(hi), 64'd1);
    check("stable_lo", 64'(lo), 64'd333);
    @(negedge clk);
    op = OP_DIVU;
    lhs = 32'd50;
    rhs = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy_done", 64'({busy, done}), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    d0 = dones;
    repeat (60) @(negedge clk);
    check("abort_no_done", 64'(dones - d0), 64'd0);
    issue8(OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00, "mult8_min", n0);
    wait8(n0, "mult8_min");
    issue8(OP_MULTU, 8'h0F, 8'h11, 8'h00, 8'hFF, "b2b8", n0);
    check("b2b8_accepted", 64'(busy8), 64'd1);
    wait8(n0, "b2b8");
    @(negedge clk);
    issue8(OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80, "div8_overflow", n0);
    wait8(n0, "div8_overflow");
    @(negedge clk);
    issue8(OP_DIV, 8'h85, 8'h07, 8'hFC, 8'hEF, "div8_neg123by7", n0);
    wait8(n0, "div8_neg123by7");
    repeat (3) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
